// File: rtl/mem_arbiter.sv
// Three-port single-memory arbiter: host (top priority) plus fetch/data round-robin.
// The host port is only active when MEM_ARB_HOST_EN is defined.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          rvalid,
  output logic [1:0]    rid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t        state, state_nx;
  logic [1:0]    owner, owner_nx;
  logic          we_r, we_nx;
  logic [AW-1:0] addr_r, addr_nx;
  logic [DW-1:0] wdata_r, wdata_nx;
  logic          rr, rr_nx;     // 0: fetch wins a fetch/data tie
  logic          host_req;

`ifdef MEM_ARB_HOST_EN
  assign host_req = h_req;
`else
  // Port stays connected but can never win arbitration.
  assign host_req = h_req & 1'b0;
`endif

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    we_nx    = we_r;
    addr_nx  = addr_r;
    wdata_nx = wdata_r;
    rr_nx    = rr;
    case (state)
      ACC: state_nx = RESP;
      default: begin
        state_nx = IDLE;
        if (host_req) begin
          state_nx = ACC;
          owner_nx = 2'd2;
          we_nx    = h_we;
          addr_nx  = h_addr;
          wdata_nx = h_wdata;
        end else if (if_req && (!d_req || !rr)) begin
          state_nx = ACC;
          owner_nx = 2'd0;
          we_nx    = 1'b0;
          addr_nx  = if_addr;
          rr_nx    = ~rr;
        end else if (d_req) begin
          state_nx = ACC;
          owner_nx = 2'd1;
          we_nx    = d_we;
          addr_nx  = d_addr;
          wdata_nx = d_wdata;
          rr_nx    = ~rr;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= '0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rr      <= 1'b0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      we_r    <= we_nx;
      addr_r  <= addr_nx;
      wdata_r <= wdata_nx;
      rr      <= rr_nx;
    end
  end

  assign mem_en    = (state == ACC);
  assign mem_we    = mem_en & we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

  assign if_gnt = mem_en && (owner == 2'd0);
  assign d_gnt  = mem_en && (owner == 2'd1);
`ifdef MEM_ARB_HOST_EN
  assign h_gnt  = mem_en && (owner == 2'd2);
`else
  assign h_gnt  = 1'b0;
`endif

  assign rvalid = (state == RESP) && !we_r;
  assign rid    = owner;
  assign rdata  = rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a cycle-count reference model predicts grants
// and read data, a negedge monitor checks them. Honours MEM_ARB_HOST_EN.
module tb_mem_arbiter;

`ifdef MEM_ARB_HOST_EN
  localparam bit HOST = 1'b1;
`else
  localparam bit HOST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       if_req, if_gnt, d_req, d_we, d_gnt, h_req, h_we, h_gnt;
  logic [7:0] if_addr, d_addr, d_wdata, h_addr, h_wdata;
  logic       rvalid, mem_en, mem_we;
  logic [1:0] rid;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_gnt(h_gnt),
    .rvalid(rvalid), .rid(rid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    logic [31:0] v;
    v = i * 29 + 7;
    return (i == 5) ? 8'h23 : v[7:0];
  endfunction

  // Behavioural memory seen by the DUT: one-cycle read latency
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct { int cyc; int who; bit we; logic [7:0] addr; logic [7:0] wd; } gexp_t;
  typedef struct { int cyc; int who; logic [7:0] data; } rexp_t;
  gexp_t exp_g[$];
  rexp_t exp_r[$];

  bit run    = 1'b0;
  bit mon_on = 1'b0;

  // Reference model: one arbitration every other cycle at most, grant one cycle
  // after the decision, read data two cycles after it.
  logic [7:0] mm [256];
  bit         rr_m = 1'b0;
  int         next_arb = 0;
  initial begin
    int who; bit we; logic [7:0] a, wd;
    for (int i = 0; i < 256; i++) mm[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (run && cyc >= next_arb) begin
        who = -1; we = 1'b0; a = '0; wd = '0;
        if (HOST && h_req)        who = 2;
        else if (if_req && d_req) who = rr_m ? 1 : 0;
        else if (if_req)          who = 0;
        else if (d_req)           who = 1;
        if (who >= 0) begin
          case (who)
            0: begin a = if_addr; end
            1: begin we = d_we; a = d_addr; wd = d_wdata; end
            default: begin we = h_we; a = h_addr; wd = h_wdata; end
          endcase
          if (who != 2) rr_m = !rr_m;
          exp_g.push_back('{cyc: cyc + 1, who: who, we: we, addr: a, wd: wd});
          if (we) mm[a] = wd;
          else exp_r.push_back('{cyc: cyc + 2, who: who, data: mm[a]});
          next_arb = cyc + 2;
        end
      end
    end
  end

  logic seen_if = 1'b0, seen_d = 1'b0, seen_h = 1'b0;
  always @(negedge clk) begin
    seen_if <= if_gnt;
    seen_d  <= d_gnt;
    seen_h  <= h_gnt;
  end

  // Monitor
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (mon_on) begin
      if (mem_en || if_gnt || d_gnt || h_gnt) begin
        if (exp_g.size() == 0) chk("unexpected_grant", {h_gnt, d_gnt, if_gnt}, 0);
        else begin
          g = exp_g.pop_front();
          chk("grant_cycle", cyc, g.cyc);
          chk("grant_vec", {h_gnt, d_gnt, if_gnt}, 32'd1 << g.who);
          chk("grant_mem_en", mem_en, 1);
          chk("grant_mem_we", mem_we, g.we);
          chk("grant_addr", mem_addr, g.addr);
          if (g.we) chk("grant_wdata", mem_wdata, g.wd);
        end
      end else begin
        chk("idle_mem_we", mem_we, 0);
        if (exp_g.size() > 0 && exp_g[0].cyc <= cyc) begin
          chk("missing_grant", cyc, exp_g[0].cyc);
          void'(exp_g.pop_front());
        end
      end
      if (rvalid) begin
        if (exp_r.size() == 0) chk("unexpected_rvalid", rvalid, 0);
        else begin
          r = exp_r.pop_front();
          chk("rvalid_cycle", cyc, r.cyc);
          chk("rid", rid, r.who);
          chk("rdata", rdata, r.data);
        end
      end else if (exp_r.size() > 0 && exp_r[0].cyc <= cyc) begin
        chk("missing_rvalid", cyc, exp_r[0].cyc);
        void'(exp_r.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    rst = 1'b0;
    if_req = 1'b1; d_req = 1'b1; h_req = 1'b1;
    d_we = 1'b0; h_we = 1'b1;
    if_addr = 8'h05; d_addr = '0; d_wdata = '0; h_addr = '0; h_wdata = '0;

    // Reset with every request high
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", {h_gnt, d_gnt, if_gnt}, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_rid", rid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end

    // Release with only fetch of 0x05 pending: arbitrates in the first cycle out of reset
    @(posedge clk); #1;
    rst = 1'b1; d_req = 1'b0; h_req = 1'b0;
    run = 1'b1; mon_on = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      if (seen_if) begin if_req = 1'b0; got = 1'b1; end
    end
    chk("fetch_grant_seen", got, 1);

    // Fairness: both held high
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 8'h11; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h12;
    repeat (16) @(posedge clk);
    #1; if_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk);

`ifdef MEM_ARB_HOST_EN
    #1;
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'hFE; h_wdata = 8'h02;
    if_req = 1'b1; if_addr = 8'hFE; d_req = 1'b1; d_addr = 8'h01;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      if (seen_h) begin h_req = 1'b0; got = 1'b1; end
    end
    chk("host_grant_seen", got, 1);
    repeat (6) @(posedge clk);
    #1; if_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk);
`endif

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (seen_if || !if_req) begin
        if_req = ($urandom_range(0, 9) < 4);
        if_addr = 8'($urandom_range(0, 15));
      end
      if (seen_d || !d_req) begin
        d_req = ($urandom_range(0, 9) < 4);
        d_we = 1'($urandom);
        d_addr = 8'($urandom_range(0, 15));
        d_wdata = 8'($urandom);
      end
      if (!HOST) h_req = 1'($urandom);
      else if (seen_h || !h_req) h_req = ($urandom_range(0, 9) < 2);
      if (seen_h || !HOST || !h_req) begin
        h_we = 1'($urandom);
        h_addr = 8'($urandom_range(0, 15));
        h_wdata = 8'($urandom);
      end
    end
    #1; if_req = 1'b0; d_req = 1'b0; h_req = 1'b0;
    repeat (6) @(posedge clk);
    chk("drain_grants", exp_g.size(), 0);
    chk("drain_reads", exp_r.size(), 0);

    // Abort a data read by resetting during its access cycle
    run = 1'b0; mon_on = 1'b0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h03;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (d_gnt) got = 1'b1;
    end
    chk("abort_grant_seen", got, 1);
    rst = 1'b0;
    @(negedge clk);
    d_req = 1'b0;
    chk("abort_rvalid", rvalid, 0);
    chk("abort_mem_en", mem_en, 0);
    chk("abort_d_gnt", d_gnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rvalid", rvalid, 0);
      chk("abort_no_retry", mem_en, 0);
    end

`ifndef MEM_ARB_HOST_EN
    @(posedge clk); #1;
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h07;
    repeat (10) begin
      @(negedge clk);
      chk("hostoff_h_gnt", h_gnt, 0);
      chk("hostoff_mem_en", mem_en, 0);
    end
    h_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
